// File: rtl/root_5_sequential.sv
// root_5_sequential: multi-cycle integer fifth root, floor(x^(1/5)).
// The root is resolved one bit per trial, MSB first. Each trial raises the
// candidate to the fifth power with four multiplies on one shared
// multiplier and keeps the bit if cand^5 <= x. Latency is fixed at
// 5*ROOT_W edges from the accepting edge to the DONE state.
//
// Handshake: run is sampled on each rising edge. It is accepted in IDLE and
// in DONE, where it is also the back-to-back restart. It is ignored while
// busy. ready is a one-cycle pulse in DONE. root holds its value until the
// next accepted run.
module root_5_sequential #(
    parameter int WIDTH = 18
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] x,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] root,
    output logic [1:0]       state_dbg
);

    localparam int ROOT_W = (WIDTH + 4) / 5;
    localparam int BIT_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
    localparam int PROD_W = WIDTH + ROOT_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TRY  = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  p;
    logic [ROOT_W-1:0] root_r;
    logic [ROOT_W-1:0] cand;
    logic [BIT_W-1:0]  bit_idx;
    logic              over;
    logic [1:0]        mcnt;

    logic [ROOT_W-1:0] cand_try;
    logic [PROD_W-1:0] prod;
    logic              prod_over;
    logic              over_next;

    // Candidate for the current bit, and the shared multiply with its
    // overflow test. p is kept at or below r_x while !over, so prod always
    // fits in WIDTH+ROOT_W bits.
    always_comb begin
        cand_try  = root_r | (ROOT_W'(1) << bit_idx);
        prod      = PROD_W'(p) * PROD_W'(cand);
        prod_over = (prod > PROD_W'(r_x));
        over_next = over | prod_over;
    end

    assign root      = {{(WIDTH-ROOT_W){1'b0}}, root_r};
    assign state_dbg = state;

    // Control FSM and datapath registers; busy/ready are registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            r_x     <= '0;
            p       <= '0;
            root_r  <= '0;
            cand    <= '0;
            bit_idx <= '0;
            over    <= 1'b0;
            mcnt    <= 2'd0;
            busy    <= 1'b0;
            ready   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    if (run) begin
                        r_x     <= x;
                        root_r  <= '0;
                        bit_idx <= BIT_W'(ROOT_W - 1);
                        busy    <= 1'b1;
                        state   <= S_TRY;
                    end
                end
                S_TRY: begin
                    cand  <= cand_try;
                    p     <= {{(WIDTH-ROOT_W){1'b0}}, cand_try};
                    over  <= 1'b0;
                    mcnt  <= 2'd0;
                    state <= S_MUL;
                end
                S_MUL: begin
                    // Once over is set, p is frozen and later products are
                    // don't-care; the sticky flag alone decides the bit.
                    if (!over && !prod_over) begin
                        p <= prod[WIDTH-1:0];
                    end
                    over <= over_next;
                    mcnt <= mcnt + 2'd1;
                    if (mcnt == 2'd3) begin
                        if (!over_next) begin
                            root_r[bit_idx] <= 1'b1;
                        end
                        if (bit_idx == '0) begin
                            busy  <= 1'b0;
                            ready <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            bit_idx <= bit_idx - BIT_W'(1);
                            state   <= S_TRY;
                        end
                    end
                end
                S_DONE: begin
                    ready <= 1'b0;
                    if (run) begin
                        r_x     <= x;
                        root_r  <= '0;
                        bit_idx <= BIT_W'(ROOT_W - 1);
                        busy    <= 1'b1;
                        state   <= S_TRY;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_root_5_sequential.sv
// tb_root_5_sequential: directed and round-trip checks of root_5_sequential.
// Drivers push the expected root and the issue cycle into queues; a monitor
// on the falling edge pops and compares whenever ready is seen.
module tb_root_5_sequential;

    localparam int WIDTH = 18;

    logic             clock;
    logic             reset;
    logic             run;
    logic [WIDTH-1:0] x;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] root;
    logic [1:0]       state_dbg;

    int unsigned      cyc;
    int               checks;
    int               passed;
    logic [WIDTH-1:0] exp_q[$];
    int unsigned      iss_q[$];

    root_5_sequential #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .x         (x),
        .busy      (busy),
        .ready     (ready),
        .root      (root),
        .state_dbg (state_dbg)
    );

    // Clock and edge counter.
    initial clock = 1'b0;
    always #5 clock = ~clock;
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic longint pow5(input longint n);
        return n * n * n * n * n;
    endfunction

    // Reference root by linear search from zero.
    function automatic logic [WIDTH-1:0] ref_root(input logic [WIDTH-1:0] v);
        longint r = 0;
        while (pow5(r + 1) <= longint'(v)) r++;
        return WIDTH'(r);
    endfunction

    // Monitor: every ready pulse must match the oldest pending result.
    always @(negedge clock) begin
        if (!reset && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_ready: ready=1 with nothing pending, root=%0d cycle %0d", root, cyc);
            end else begin
                logic [WIDTH-1:0] e;
                int unsigned      t;
                e = exp_q.pop_front();
                t = iss_q.pop_front();
                check("root", 32'(root), 32'(e));
                check("latency", cyc - t, 32'd21);
            end
        end
    end

    // Drivers, all called on a falling edge.
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            checks++;
            $display("FAIL idle_timeout: busy=%0d after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic start(input logic [WIDTH-1:0] v, input bit expect_res, input logic [WIDTH-1:0] e);
        wait_idle();
        run = 1'b1;
        x   = v;
        if (expect_res) begin
            exp_q.push_back(e);
            iss_q.push_back(cyc);
        end
        @(negedge clock);
        run = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ready && n < 60);
        if (!ready) begin
            checks++;
            $display("FAIL ready_timeout: ready=%0d after %0d cycles, expected 1", ready, n);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] e;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int dev;
        checks = 0;
        passed = 0;
        reset  = 1'b1;
        run    = 1'b0;
        x      = '0;

        vecs[0] = '{18'd0,      18'd0};
        vecs[1] = '{18'd1,      18'd1};
        vecs[2] = '{18'd31,     18'd1};
        vecs[3] = '{18'd32,     18'd2};
        vecs[4] = '{18'd242,    18'd2};
        vecs[5] = '{18'd243,    18'd3};
        vecs[6] = '{18'd248831, 18'd11};
        vecs[7] = '{18'd248832, 18'd12};
        vecs[8] = '{18'd262143, 18'd12};

        // Reset state.
        repeat (2) @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_root", 32'(root), 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Reset mid-operation: no ready must follow.
        start(18'd1000, 1'b0, '0);
        repeat (6) @(negedge clock);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_ready", 32'(ready), 32'd0);
        check("async_root", 32'(root), 32'd0);
        check("async_state", 32'(state_dbg), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        start(18'd1000, 1'b1, 18'd3);

        // Small and boundary values.
        foreach (vecs[i]) start(vecs[i].v, 1'b1, vecs[i].e);

        // run pulse with a different x while busy is ignored.
        start(18'd100, 1'b1, 18'd2);
        repeat (4) @(negedge clock);
        run = 1'b1;
        x   = 18'd5000;
        @(negedge clock);
        run = 1'b0;

        // Back-to-back: run held through DONE restarts with the new x.
        wait_idle();
        run = 1'b1;
        x   = 18'd243;
        exp_q.push_back(18'd3);
        iss_q.push_back(cyc);
        wait_ready();
        x = 18'd32;
        exp_q.push_back(18'd2);
        iss_q.push_back(cyc);
        wait_ready();
        x = 18'd248832;
        exp_q.push_back(18'd12);
        iss_q.push_back(cyc);
        wait_ready();
        run = 1'b0;

        // root holds while run stays low.
        dev = 0;
        repeat (30) begin
            @(negedge clock);
            if (root !== 18'd12) dev++;
        end
        check("root_hold_dev", 32'(dev), 32'd0);
        check("root_hold", 32'(root), 32'd12);

        // Round trip on exact fifth powers.
        for (int n = 0; n <= 12; n++) start(WIDTH'(pow5(n)), 1'b1, WIDTH'(n));

        // Random operands against the search reference.
        for (int k = 0; k < 8; k++) begin
            logic [WIDTH-1:0] v;
            v = WIDTH'($urandom_range(0, 262143));
            start(v, 1'b1, ref_root(v));
        end

        // Drain and report.
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                @(negedge clock);
                n++;
            end
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
